// File: rtl/mem_lsu_if.sv
// Memory-side bus of the load/store unit: request/ack handshake plus word-wide data.
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: aligns the address, builds byte enables and replicated store data,
// runs a req/ack handshake and returns sign/zero-extended load data with fault codes.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  fault_o,
    output logic [31:0] rdata_o,
    mem_lsu_if.master   mem
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // Counter value seen in the last ACCESS cycle allowed before timing out.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic        we_q, we_d;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Decode the incoming request: legality, alignment, lane enables and store data.
    always_comb begin
        illegal    = is_store_i ? (funct3_i > 3'd2)
                                : (funct3_i == 3'd3 || funct3_i[2:1] == 2'b11);
        misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                     (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
        be_calc    = 4'b0000;
        wdata_rep  = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_calc   = 4'b0001 << addr_i[1:0];
                wdata_rep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_calc   = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            2'b10:   be_calc = 4'b1111;
            default: be_calc = 4'b0000;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem.rdata[7:0];
            2'd1:    ld_byte = mem.rdata[15:8];
            2'd2:    ld_byte = mem.rdata[23:16];
            default: ld_byte = mem.rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd5:    ld_ext = {16'd0, ld_half};
            default: ld_ext = mem.rdata;
        endcase
    end

    // Next-state logic for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        maddr_d  = maddr_q;
        be_d     = be_q;
        mwdata_d = mwdata_q;
        we_d     = we_q;
        unique case (state_q)
            StIdle: begin
                fault_d = 2'd0;
                if (start_i) begin
                    funct3_d = funct3_i;
                    off_d    = addr_i[1:0];
                    if (illegal) begin
                        state_d = StResp;
                        fault_d = 2'd2;
                    end else if (misaligned) begin
                        state_d = StResp;
                        fault_d = 2'd1;
                    end else begin
                        // Bus registers only move for accesses that will really go out.
                        state_d  = StAccess;
                        cnt_d    = 16'd0;
                        maddr_d  = {addr_i[31:2], 2'b00};
                        be_d     = be_calc;
                        mwdata_d = wdata_rep;
                        we_d     = is_store_i;
                    end
                end
            end
            StAccess: begin
                if (mem.ack) begin
                    if (!we_q) rdata_d = ld_ext;
                    state_d = StResp;
                    fault_d = 2'd0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StResp;
                    fault_d = 2'd3;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                fault_d = 2'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            fault_q  <= 2'd0;
            cnt_q    <= 16'd0;
            rdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            maddr_q  <= 32'd0;
            be_q     <= 4'd0;
            mwdata_q <= 32'd0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            maddr_q  <= maddr_d;
            be_q     <= be_d;
            mwdata_q <= mwdata_d;
            we_q     <= we_d;
        end
    end

    // Outputs decode only from registers.
    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StResp);
    assign fault_o   = fault_q;
    assign rdata_o   = rdata_q;
    assign mem.req   = (state_q == StAccess);
    assign mem.we    = we_q;
    assign mem.addr  = maddr_q;
    assign mem.be    = be_q;
    assign mem.wdata = mwdata_q;

endmodule
